regfile_write_arbiter: RTL

- Shares the single write port of the 32x32 register file (regWrite/writeRegister/writeData) between two writeback sources: A = ALU result, B = memory load.
- Each source has its own 2-entry queue; the block issues one write per cycle, round-robin between the sources.
- Flags read hazards for the two decode read addresses while a matching write is still pending.
- Sits between the writeback sources and the register file; its three write outputs drive the register file's write inputs directly.

---
 rtl/regfile_write_arbiter_if.sv | 30 +++
 rtl/regfile_write_arbiter.sv | 132 +++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter_if.sv
// Bus bundle between the two writeback sources, the decode read ports and the
// register file write port.
interface regfile_write_arbiter_if;
    logic        aValid;
    logic [4:0]  aAddr;
    logic [31:0] aData;
    logic        aReady;
    logic        bValid;
    logic [4:0]  bAddr;
    logic [31:0] bData;
    logic        bReady;
    logic [4:0]  readRegister1;
    logic [4:0]  readRegister2;
    logic        hazard1;
    logic        hazard2;
    logic        regWrite;
    logic [4:0]  writeRegister;
    logic [31:0] writeData;
    logic        idle;

    modport slave (
        input  aValid, aAddr, aData, bValid, bAddr, bData, readRegister1, readRegister2,
        output aReady, bReady, hazard1, hazard2, regWrite, writeRegister, writeData, idle
    );

    modport master (
        output aValid, aAddr, aData, bValid, bAddr, bData, readRegister1, readRegister2,
        input  aReady, bReady, hazard1, hazard2, regWrite, writeRegister, writeData, idle
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between the ALU (A) and load (B) writeback
// sources: 2-entry queue per source, round-robin issue, read-hazard flags.
module regfile_write_arbiter #(
    parameter bit ZERO_PROTECT = 1'b1,
    parameter int QDEPTH       = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    regfile_write_arbiter_if.slave  bus
);
    localparam logic [1:0] FULL = QDEPTH[1:0];

    typedef enum logic {PREF_A = 1'b0, PREF_B = 1'b1} rr_t;

    rr_t         r_rr;
    rr_t         w_rr_next;
    logic [4:0]  r_q_addr [2][2];
    logic [31:0] r_q_data [2][2];
    logic        r_wp [2];
    logic        r_rp [2];
    logic [1:0]  r_cnt [2];
    logic        r_reg_write;
    logic [4:0]  r_write_reg;
    logic [31:0] r_write_data;

    logic        w_valid_in [2];
    logic [4:0]  w_addr_in [2];
    logic [31:0] w_data_in [2];
    logic        w_ready [2];
    logic        w_push [2];
    logic        w_pop [2];
    logic        w_nonempty [2];
    logic        w_issue;
    logic        w_sel;
    logic        w_haz1;
    logic        w_haz2;

    assign w_valid_in[0] = bus.aValid;
    assign w_valid_in[1] = bus.bValid;
    assign w_addr_in[0]  = bus.aAddr;
    assign w_addr_in[1]  = bus.bAddr;
    assign w_data_in[0]  = bus.aData;
    assign w_data_in[1]  = bus.bData;

    // Readiness looks only at the registered count, never at a same-edge pop.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            w_ready[s]    = !reset && (r_cnt[s] != FULL);
            w_push[s]     = w_valid_in[s] && w_ready[s] && !(ZERO_PROTECT && (w_addr_in[s] == 5'd0));
            w_nonempty[s] = (r_cnt[s] != 2'd0);
        end
    end

    always_comb begin
        w_issue   = w_nonempty[0] || w_nonempty[1];
        w_sel     = 1'b0;
        w_rr_next = r_rr;
        if (w_nonempty[0] && w_nonempty[1]) begin
            w_sel = (r_rr == PREF_B);
        end else begin
            w_sel = w_nonempty[1];
        end
        if (w_issue) begin
            w_rr_next = w_sel ? PREF_A : PREF_B;
        end
        w_pop[0] = w_issue && !w_sel;
        w_pop[1] = w_issue && w_sel;
    end

    // An entry is live when the queue is full, or it is the head of a 1-entry queue.
    always_comb begin
        w_haz1 = 1'b0;
        w_haz2 = 1'b0;
        for (int s = 0; s < 2; s++) begin
            for (int j = 0; j < 2; j++) begin
                if ((r_cnt[s] == 2'd2) || ((r_cnt[s] == 2'd1) && (r_rp[s] == j[0]))) begin
                    if (r_q_addr[s][j] == bus.readRegister1) w_haz1 = 1'b1;
                    if (r_q_addr[s][j] == bus.readRegister2) w_haz2 = 1'b1;
                end
            end
        end
        if (r_reg_write && (r_write_reg == bus.readRegister1)) w_haz1 = 1'b1;
        if (r_reg_write && (r_write_reg == bus.readRegister2)) w_haz2 = 1'b1;
        if (bus.readRegister1 == 5'd0) w_haz1 = 1'b0;
        if (bus.readRegister2 == 5'd0) w_haz2 = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr         <= PREF_A;
            r_reg_write  <= 1'b0;
            r_write_reg  <= 5'd0;
            r_write_data <= 32'd0;
            for (int s = 0; s < 2; s++) begin
                r_wp[s]  <= 1'b0;
                r_rp[s]  <= 1'b0;
                r_cnt[s] <= 2'd0;
            end
        end else begin
            r_rr        <= w_rr_next;
            r_reg_write <= w_issue;
            if (w_issue) begin
                r_write_reg  <= r_q_addr[w_sel][r_rp[w_sel]];
                r_write_data <= r_q_data[w_sel][r_rp[w_sel]];
            end
            for (int s = 0; s < 2; s++) begin
                if (w_push[s]) r_wp[s] <= ~r_wp[s];
                if (w_pop[s])  r_rp[s] <= ~r_rp[s];
                r_cnt[s] <= r_cnt[s] + {1'b0, w_push[s]} - {1'b0, w_pop[s]};
            end
        end
    end

    // Queue storage carries no reset; liveness is tracked by the counts alone.
    always_ff @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (!reset && w_push[s]) begin
                r_q_addr[s][r_wp[s]] <= w_addr_in[s];
                r_q_data[s][r_wp[s]] <= w_data_in[s];
            end
        end
    end

    assign bus.aReady        = w_ready[0];
    assign bus.bReady        = w_ready[1];
    assign bus.hazard1       = w_haz1;
    assign bus.hazard2       = w_haz2;
    assign bus.regWrite      = r_reg_write;
    assign bus.writeRegister = r_write_reg;
    assign bus.writeData     = r_write_data;
    assign bus.idle          = (r_cnt[0] == 2'd0) && (r_cnt[1] == 2'd0) && !r_reg_write;
endmodule
